// File: rtl/display_scan_monitor_if.sv
// Snooped scan bus between the 7-segment scan driver and its monitor.
// Both buses are active-low: digit enables and segment lines.
interface display_scan_monitor_if;
   logic [7:0] dig_n;
   logic [7:0] seg_n;

   modport master (output dig_n, output seg_n);
   modport slave  (input  dig_n, input  seg_n);
endinterface

// File: rtl/display_scan_monitor.sv
// Decodes the multiplexed 7-segment scan back into HH:MM:SS, publishes each
// complete in-range frame with a strobe and flags any malformed scan.
module display_scan_monitor (
   input  logic                         clk,
   input  logic                         rst_n,
   display_scan_monitor_if.slave        scan,
   output logic [3:0]                   sec_u_o,
   output logic [2:0]                   sec_t_o,
   output logic [3:0]                   min_u_o,
   output logic [2:0]                   min_t_o,
   output logic [3:0]                   hour_u_o,
   output logic [1:0]                   hour_t_o,
   output logic                         frame_valid_o,
   output logic                         err_o,
   output logic [7:0]                   err_count_o,
   output logic                         locked_o
);

   localparam int unsigned NDIG = 6;
   localparam int unsigned IW   = 3;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WAIT_BLANK} state_e;

   state_e          state_q;
   logic [7:0]      dig_q, seg_q;
   logic [7:0]      prev_dig_q, prev_seg_q;
   logic [IW-1:0]   exp_q;
   logic [3:0]      val_q [NDIG];

   logic [5:0]      dig_lo_c;
   logic            is_digit_c, is_blank_c, pat_ok_c, dp_ok_c, good_digit_c;
   logic            repeat_c, range_ok_c;
   logic [IW-1:0]   slot_idx_c;
   logic [6:0]      pat_c;
   logic [3:0]      val_c;
   logic            accept_c, publish_c, fault_c;
   logic [7:0]      err_count_d;

   // Slot classification and segment decode of the registered bus copy
   always_comb begin
      dig_lo_c   = ~dig_q[5:0];
      is_digit_c = (dig_q[7:6] == 2'b11) && $onehot(dig_lo_c);
      is_blank_c = (dig_q == 8'hFF);
      slot_idx_c = '0;
      for (int k = 0; k < int'(NDIG); k++) begin
         if (dig_lo_c[k]) slot_idx_c = IW'(k);
      end
      pat_c    = ~{seg_q[1], seg_q[2], seg_q[3], seg_q[4], seg_q[5], seg_q[6], seg_q[7]};
      pat_ok_c = 1'b1;
      case (pat_c)
         7'h3F:   val_c = 4'd0;
         7'h06:   val_c = 4'd1;
         7'h5B:   val_c = 4'd2;
         7'h4F:   val_c = 4'd3;
         7'h66:   val_c = 4'd4;
         7'h6D:   val_c = 4'd5;
         7'h7D:   val_c = 4'd6;
         7'h07:   val_c = 4'd7;
         7'h7F:   val_c = 4'd8;
         7'h6F:   val_c = 4'd9;
         default: begin val_c = 4'd0; pat_ok_c = 1'b0; end
      endcase
      // Decimal points separate HH.MM.SS, so only digits 2 and 4 carry one
      dp_ok_c      = (~seg_q[0]) == ((slot_idx_c == IW'(2)) || (slot_idx_c == IW'(4)));
      good_digit_c = is_digit_c && pat_ok_c && dp_ok_c;
      repeat_c     = (dig_q == prev_dig_q) && (seg_q == prev_seg_q);
      range_ok_c   = (val_q[1] <= 4'd5) && (val_q[3] <= 4'd5) && (val_q[5] <= 4'd2)
                     && !((val_q[5] == 4'd2) && (val_q[4] > 4'd3));
      err_count_d  = (err_count_o == 8'hFF) ? err_count_o : err_count_o + 8'd1;
   end

   // Event decision for the current state
   always_comb begin
      accept_c  = 1'b0;
      publish_c = 1'b0;
      fault_c   = 1'b0;
      case (state_q)
         S_IDLE: accept_c = good_digit_c && (slot_idx_c == '0);
         S_CAPTURE: begin
            if (good_digit_c && (slot_idx_c == exp_q)) accept_c = 1'b1;
            else if (!repeat_c)                        fault_c  = 1'b1;
         end
         S_WAIT_BLANK: begin
            if (is_blank_c) begin
               publish_c = range_ok_c;
               fault_c   = !range_ok_c;
            end else if (!repeat_c) begin
               fault_c = 1'b1;
            end
         end
         default: fault_c = 1'b1;
      endcase
   end

   // Input register, frame FSM and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dig_q         <= 8'hFF;
         seg_q         <= 8'hFF;
         prev_dig_q    <= 8'hFF;
         prev_seg_q    <= 8'hFF;
         state_q       <= S_IDLE;
         exp_q         <= '0;
         for (int k = 0; k < int'(NDIG); k++) val_q[k] <= 4'd0;
         sec_u_o       <= '0;
         sec_t_o       <= '0;
         min_u_o       <= '0;
         min_t_o       <= '0;
         hour_u_o      <= '0;
         hour_t_o      <= '0;
         frame_valid_o <= 1'b0;
         err_o         <= 1'b0;
         err_count_o   <= '0;
         locked_o      <= 1'b0;
      end else begin
         dig_q         <= scan.dig_n;
         seg_q         <= scan.seg_n;
         frame_valid_o <= 1'b0;
         err_o         <= 1'b0;
         if (fault_c) begin
            err_o       <= 1'b1;
            err_count_o <= err_count_d;
            locked_o    <= 1'b0;
            state_q     <= S_IDLE;
         end else if (publish_c) begin
            sec_u_o       <= val_q[0];
            sec_t_o       <= val_q[1][2:0];
            min_u_o       <= val_q[2];
            min_t_o       <= val_q[3][2:0];
            hour_u_o      <= val_q[4];
            hour_t_o      <= val_q[5][1:0];
            frame_valid_o <= 1'b1;
            locked_o      <= 1'b1;
            state_q       <= S_IDLE;
         end else if (accept_c) begin
            val_q[slot_idx_c] <= val_c;
            prev_dig_q        <= dig_q;
            prev_seg_q        <= seg_q;
            exp_q             <= slot_idx_c + IW'(1);
            state_q           <= (slot_idx_c == IW'(5)) ? S_WAIT_BLANK : S_CAPTURE;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_monitor.sv
// Directed self-checking bench for display_scan_monitor.
module tb_display_scan_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   display_scan_monitor_if scan_if ();

   logic [3:0] sec_u, min_u, hour_u;
   logic [2:0] sec_t, min_t;
   logic [1:0] hour_t;
   logic       frame_valid, err, locked;
   logic [7:0] err_count;

   display_scan_monitor dut (
      .clk(clk), .rst_n(rst_n), .scan(scan_if.slave),
      .sec_u_o(sec_u), .sec_t_o(sec_t), .min_u_o(min_u), .min_t_o(min_t),
      .hour_u_o(hour_u), .hour_t_o(hour_t), .frame_valid_o(frame_valid),
      .err_o(err), .err_count_o(err_count), .locked_o(locked)
   );

   wire [19:0] pub = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};
   localparam logic [19:0] T235947 = {2'd2, 4'd3, 3'd5, 4'd9, 3'd4, 4'd7};
   localparam logic [19:0] T120830 = {2'd1, 4'd2, 3'd0, 4'd8, 3'd3, 4'd0};

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fv_seen = 0, err_seen = 0, both_seen = 0;
   int fv_last = 0, fv_prev = 0;
   int fv0, er0;
   logic [7:0] fd [7];
   logic [7:0] fs [7];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_valid) begin fv_seen++; fv_prev = fv_last; fv_last = cyc; end
      if (err) err_seen++;
      if (frame_valid && err) both_seen++;
   end

   function automatic logic [6:0] pat_of(input int v);
      case (v)
         0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
         4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
         8: return 7'h7F; default: return 7'h6F;
      endcase
   endfunction

   // seg_n index 7..0 = a b c d e f g dp, pattern bits 6..0 = g f e d c b a
   function automatic logic [7:0] enc(input logic [6:0] p, input logic dp);
      logic [7:0] s;
      s = {p[0], p[1], p[2], p[3], p[4], p[5], p[6], dp};
      return ~s;
   endfunction

   function automatic logic [7:0] dsel(input int k);
      logic [7:0] one;
      one = 8'd1;
      return ~(one << k);
   endfunction

   task automatic put(input logic [7:0] d, input logic [7:0] s);
      @(posedge clk); #1;
      scan_if.dig_n = d;
      scan_if.seg_n = s;
   endtask

   task automatic load_time(input int ht, hu, mt, mu, st, su);
      int v [6];
      v = '{su, st, mu, mt, hu, ht};
      for (int k = 0; k < 6; k++) begin
         fd[k] = dsel(k);
         fs[k] = enc(pat_of(v[k]), (k == 2) || (k == 4));
      end
      fd[6] = 8'hFF;
      fs[6] = 8'hFF;
   endtask

   task automatic play(input int hold, input int blank_hold);
      for (int i = 0; i < 7; i++)
         repeat ((i < 6) ? hold : blank_hold) put(fd[i], fs[i]);
   endtask

   task automatic flush();
      repeat (3) put(8'hFF, 8'hFF);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      scan_if.dig_n = 8'hFF;
      scan_if.seg_n = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (pub !== 20'd0) begin errors++; $display("FAIL reset_time got %h exp 0", pub); end
      checks++; if ({frame_valid, err, locked} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {frame_valid, err, locked}); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
      rst_n = 1'b1;
   endtask

   task automatic test_good_frame();
      fv0 = fv_seen; er0 = err_seen;
      load_time(2, 3, 5, 9, 4, 7);
      play(1, 1);
      @(posedge clk); @(posedge clk); #1;
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_fv_latency got %b exp 1", frame_valid); end
      checks++; if (pub !== T235947) begin errors++; $display("FAIL good_time got %h exp %h", pub, T235947); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL good_locked got %b exp 1", locked); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL good_err_count got %0d exp 0", err_count); end
      @(posedge clk); #1;
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_fv_one_cycle got %b exp 0", frame_valid); end
      checks++; if (fv_seen - fv0 !== 1 || err_seen !== er0) begin errors++; $display("FAIL good_counts got fv %0d err %0d exp 1 0", fv_seen - fv0, err_seen - er0); end
   endtask

   task automatic test_back_to_back();
      fv0 = fv_seen; er0 = err_seen;
      load_time(1, 2, 0, 8, 3, 0);
      repeat (3) play(1, 1);
      flush();
      checks++; if (fv_seen - fv0 !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", fv_seen - fv0); end
      checks++; if (fv_last - fv_prev !== 7) begin errors++; $display("FAIL b2b_period got %0d exp 7", fv_last - fv_prev); end
      checks++; if (pub !== T120830) begin errors++; $display("FAIL b2b_time got %h exp %h", pub, T120830); end
      checks++; if (err_seen !== er0) begin errors++; $display("FAIL b2b_err got %0d exp 0", err_seen - er0); end
   endtask

   task automatic test_invalid_pattern();
      load_time(2, 3, 5, 9, 4, 7);
      play(1, 1);
      flush();
      fv0 = fv_seen; er0 = err_seen;
      load_time(1, 2, 0, 8, 3, 0);
      fs[3] = enc(7'h49, 1'b0);
      play(1, 1);
      flush();
      checks++; if (err_seen - er0 !== 1 || fv_seen !== fv0) begin errors++; $display("FAIL badpat_pulses got err %0d fv %0d exp 1 0", err_seen - er0, fv_seen - fv0); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL badpat_err_count got %0d exp 1", err_count); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL badpat_locked got %b exp 0", locked); end
      checks++; if (pub !== T235947) begin errors++; $display("FAIL badpat_time_held got %h exp %h", pub, T235947); end
      fv0 = fv_seen;
      load_time(1, 2, 0, 8, 3, 0);
      play(1, 1);
      flush();
      checks++; if (fv_seen - fv0 !== 1 || pub !== T120830 || locked !== 1'b1) begin errors++; $display("FAIL badpat_recover got fv %0d time %h lock %b exp 1 %h 1", fv_seen - fv0, pub, locked, T120830); end
   endtask

   task automatic test_out_of_order();
      er0 = err_seen;
      load_time(2, 3, 5, 9, 4, 7);
      fd[1] = fd[2]; fs[1] = fs[2];
      play(1, 1);
      flush();
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL order_err_count got %0d exp 2", err_count); end
      load_time(2, 3, 5, 9, 4, 7);
      fd[2] = 8'hFC;
      play(1, 1);
      flush();
      checks++; if (err_count !== 8'd3 || err_seen - er0 !== 2) begin errors++; $display("FAIL twolow_err got count %0d pulses %0d exp 3 2", err_count, err_seen - er0); end
      checks++; if (locked !== 1'b0 || pub !== T120830) begin errors++; $display("FAIL order_held got lock %b time %h exp 0 %h", locked, pub, T120830); end
   endtask

   task automatic test_range();
      fv0 = fv_seen;
      load_time(2, 4, 0, 0, 0, 0);
      play(1, 1);
      @(posedge clk); @(posedge clk); #1;
      checks++; if (err !== 1'b1 || frame_valid !== 1'b0) begin errors++; $display("FAIL range_err got err %b fv %b exp 1 0", err, frame_valid); end
      flush();
      checks++; if (err_count !== 8'd4 || fv_seen !== fv0 || pub !== T120830) begin errors++; $display("FAIL range_nopublish got count %0d fv %0d time %h exp 4 0 %h", err_count, fv_seen - fv0, pub, T120830); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL range_locked got %b exp 0", locked); end
   endtask

   task automatic test_slow_scan();
      fv0 = fv_seen; er0 = err_seen;
      load_time(2, 3, 5, 9, 4, 7);
      repeat (3) play(4, 4);
      flush();
      checks++; if (fv_seen - fv0 !== 3 || err_seen !== er0) begin errors++; $display("FAIL slow_counts got fv %0d err %0d exp 3 0", fv_seen - fv0, err_seen - er0); end
      checks++; if (fv_last - fv_prev !== 28) begin errors++; $display("FAIL slow_period got %0d exp 28", fv_last - fv_prev); end
      checks++; if (pub !== T235947 || locked !== 1'b1) begin errors++; $display("FAIL slow_time got %h lock %b exp %h 1", pub, locked, T235947); end
      er0 = err_seen;
      for (int k = 0; k < 2; k++) repeat (4) put(fd[k], fs[k]);
      repeat (2) put(fd[2], fs[2]);
      repeat (2) put(fd[2], enc(pat_of(8), 1'b1));
      flush();
      checks++; if (err_seen - er0 !== 1 || err_count !== 8'd5) begin errors++; $display("FAIL slow_change got pulses %0d count %0d exp 1 5", err_seen - er0, err_count); end
   endtask

   task automatic test_reset_mid_frame();
      load_time(2, 3, 5, 9, 4, 7);
      play(1, 1);
      flush();
      fv0 = fv_seen; er0 = err_seen;
      load_time(1, 2, 0, 8, 3, 0);
      for (int k = 0; k < 3; k++) put(fd[k], fs[k]);
      put(fd[3], fs[3]);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (pub !== 20'd0 || locked !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL midreset_clear got time %h lock %b count %0d exp 0 0 0", pub, locked, err_count); end
      rst_n = 1'b1;
      for (int k = 4; k < 7; k++) put(fd[k], fs[k]);
      flush();
      checks++; if (fv_seen !== fv0 || err_seen !== er0) begin errors++; $display("FAIL midreset_discard got fv %0d err %0d exp 0 0", fv_seen - fv0, err_seen - er0); end
      play(1, 1);
      flush();
      checks++; if (fv_seen - fv0 !== 1 || pub !== T120830) begin errors++; $display("FAIL midreset_next got fv %0d time %h exp 1 %h", fv_seen - fv0, pub, T120830); end
   endtask

   task automatic test_saturation();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      fv0 = fv_seen; er0 = err_seen;
      load_time(0, 0, 0, 0, 0, 0);
      repeat (300) begin
         put(fd[0], fs[0]);
         put(8'hFF, 8'hFF);
      end
      flush();
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", err_count); end
      checks++; if (err_seen - er0 !== 300 || fv_seen !== fv0) begin errors++; $display("FAIL sat_pulses got err %0d fv %0d exp 300 0", err_seen - er0, fv_seen - fv0); end
      checks++; if (both_seen !== 0) begin errors++; $display("FAIL fv_err_overlap got %0d exp 0", both_seen); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      scan_if.dig_n = 8'hFF;
      scan_if.seg_n = 8'hFF;
      test_reset();
      test_good_frame();
      test_back_to_back();
      test_invalid_pattern();
      test_out_of_order();
      test_range();
      test_slow_scan();
      test_reset_mid_frame();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
